vjtag_dr_engine: RTL and testbench
==================================

// Module: vjtag_dr_engine
// PURPOSE
//  Parametrised data-register engine behind the 24-bit virtual JTAG node; runs in the TCK domain.
//  Decodes the latched IR into DATA / ID / CLR / BYPASS modes and selects one of N_CH capture channels.
//  Captures, shifts and updates the selected DR, and reports shift-length errors back via ir_out.
//  Feeds the JTAG-to-AXI4-Lite command layer through upd_data/upd_ch/upd_valid.
// PARAMETERS
//  IR_W    24          IR width; must be >= 16.
//  DR_W    32          DR width, in bits.
//  N_CH    4           number of capture channels, 1..256.
//  ID_VAL  32'h4A50_0001  value captured in ID mode; truncated or zero-extended to DR_W.
// PORTS
//  clk        in   1           TCK from the virtual JTAG node
//  rst        in   1           synchronous reset, active-high
//  tdi        in   1           serial data in
//  tdo        out  1           serial data out; equals shift_reg[0]
//  ir_in      in   IR_W        IR contents from the node
//  ir_out     out  IR_W        status returned on IR capture
//  vs_cdr     in   1           virtual_state_cdr
//  vs_sdr     in   1           virtual_state_sdr
//  vs_udr     in   1           virtual_state_udr
//  vs_uir     in   1           virtual_state_uir
//  cap_data   in   N_CH*DR_W   per-channel capture words; channel k is [k*DR_W +: DR_W]
//  upd_data   out  DR_W        last valid updated word
//  upd_ch     out  8           channel of upd_data
//  upd_valid  out  1           1-cycle strobe: upd_data/upd_ch are new
// BEHAVIOUR
//  Reset values
//   - Outputs: tdo=0, upd_data=0, upd_ch=0, upd_valid=0, ir_out=0.
//   - Internal: mode=BYPASS, chan=0, cnt=0, shift_reg=0, err_short=0, err_long=0.
//  IR decode on the vs_uir cycle, opcode = ir_in[7:0], arg = ir_in[15:8]
//   - 8'h01 DATA: if arg < N_CH then mode=DATA, chan=arg; else mode=BYPASS.
//   - 8'h02 ID: mode=ID.
//   - 8'h03 CLR: err_short=0, err_long=0; mode=BYPASS.
//   - Any other opcode: mode=BYPASS.
//  DR state machine: IDLE -> CAP (vs_cdr) -> SHIFT (vs_sdr) -> UPD (vs_udr) -> IDLE
//   - CAP: cnt=0. shift_reg loads cap_data[chan] (DATA), ID_VAL (ID), or 0 (BYPASS).
//   - SHIFT, DATA or ID mode: shift_reg <= {tdi, shift_reg[DR_W-1:1]}, LSB first.
//   - SHIFT, BYPASS mode: only bit 0 is used, shift_reg[0] <= tdi, giving a 1-bit bypass.
//   - SHIFT, cnt: increments each vs_sdr cycle and saturates at DR_W+1.
//   - UPD, DATA mode, cnt==DR_W: upd_data<=shift_reg and upd_ch<=chan, both on the vs_udr edge;
//     upd_valid=1 for exactly that following cycle.
//   - UPD, DATA mode, cnt<DR_W: sets err_short; no strobe.
//   - UPD, DATA mode, cnt>DR_W: sets err_long; no strobe.
//   - UPD, ID or BYPASS mode: no strobe and no error.
//  Status
//   - ir_out = {zeros, chan[7:0], 5'b0, mode[0], err_long, err_short}.
//   - ir_out is registered and updates the cycle after any flag, chan or mode change.
//  Boundary conditions
//   - vs_cdr with vs_sdr in the same cycle (illegal): cdr wins.
//   - vs_uir during a DR scan: mode/chan change immediately; cnt is untouched.
//   - rst mid-scan: everything returns to reset values; the next scan needs a fresh vs_cdr.
//   - Consecutive UPDs: each valid one strobes; upd_valid is never held more than 1 cycle.
//   - err flags are sticky; only CLR or rst clears them.
// CONFIGURATION
//  Macro VJTAG_DR_AUTOINC_EN
//   - Defined: after each valid DATA update, chan <= (chan==N_CH-1) ? 0 : chan+1.
//     This allows burst reads/writes without re-scanning the IR.
//   - Undefined: chan changes only on vs_uir.
//   - In both cases an invalid update never advances chan.
// TESTING
//  1. Reset, then BYPASS scan: DR scan of 1 bit with tdi=1 -> tdo=1 on the next shift; no upd_valid.
//  2. DATA, ch=2, cap_data[2]=32'hDEAD_BEEF: shift 32 bits of 32'h1234_5678 ->
//     tdo stream = DEADBEEF LSB-first; upd_valid pulse with upd_data=32'h1234_5678, upd_ch=2.
//  3. DATA, ch=0: shift only 31 bits -> no upd_valid, ir_out[0]=1.
//     A 33-bit scan -> ir_out[1]=1. CLR -> both flags 0.
//  4. ID opcode: 32-bit scan -> tdo returns 32'h4A50_0001; no upd_valid.
//  5. DATA with arg=8'h07 and N_CH=4 -> BYPASS; a 32-bit scan gives no upd_valid and no error flags.
//  6. AUTOINC_EN, N_CH=4, start ch=3: three valid 32-bit scans ->
//     upd_ch = 3,0,1; without the macro -> 3,3,3.

Source files
------------

// File: rtl/vjtag_dr_engine.sv
// Data-register engine behind the virtual JTAG node (TCK domain).
// Optional VJTAG_DR_AUTOINC_EN: advance the channel after each valid DATA update.
module vjtag_dr_engine #(
    parameter int          IR_W   = 24,
    parameter int          DR_W   = 32,
    parameter int          N_CH   = 4,
    parameter logic [31:0] ID_VAL = 32'h4A50_0001
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tdi,
    output logic                 tdo,
    input  logic [IR_W-1:0]      ir_in,
    output logic [IR_W-1:0]      ir_out,
    input  logic                 vs_cdr,
    input  logic                 vs_sdr,
    input  logic                 vs_udr,
    input  logic                 vs_uir,
    input  logic [N_CH*DR_W-1:0] cap_data,
    output logic [DR_W-1:0]      upd_data,
    output logic [7:0]           upd_ch,
    output logic                 upd_valid
);

    localparam int CNT_W = $clog2(DR_W + 2);
    localparam logic [DR_W-1:0]  ID_WORD  = DR_W'(ID_VAL);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DR_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DR_W + 1);
    localparam logic [7:0]       CH_LAST  = 8'(N_CH - 1);

    typedef enum logic [1:0] {
        M_BYP  = 2'b00,
        M_DATA = 2'b01,
        M_ID   = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CAP,
        S_SHIFT,
        S_UPD
    } state_t;

    state_t           state;
    mode_t            mode;
    logic [7:0]       chan;
    logic [CNT_W-1:0] cnt;
    logic [DR_W-1:0]  shift_reg;
    logic             err_short;
    logic             err_long;
    logic [DR_W-1:0]  cap_word;
    logic [IR_W-1:0]  status;
    logic             in_scan;
    logic             unused_ir;

    assign tdo       = shift_reg[0];
    assign in_scan   = (state == S_CAP) || (state == S_SHIFT);
    assign unused_ir = ^ir_in;

    always_comb begin
        cap_word = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (chan == 8'(k)) cap_word = cap_data[k*DR_W +: DR_W];
        end
    end

    always_comb begin
        status       = '0;
        status[15:8] = chan;
        status[2]    = (mode == M_DATA);
        status[1]    = err_long;
        status[0]    = err_short;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            mode      <= M_BYP;
            chan      <= '0;
            cnt       <= '0;
            shift_reg <= '0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            upd_data  <= '0;
            upd_ch    <= '0;
            upd_valid <= 1'b0;
            ir_out    <= '0;
        end else begin
            upd_valid <= 1'b0;
            ir_out    <= status;
            // capture has priority over a simultaneous (illegal) shift
            if (vs_cdr) begin
                state <= S_CAP;
                cnt   <= '0;
                case (mode)
                    M_DATA:  shift_reg <= cap_word;
                    M_ID:    shift_reg <= ID_WORD;
                    default: shift_reg <= '0;
                endcase
            end else if (vs_sdr && in_scan) begin
                state <= S_SHIFT;
                if (mode == M_BYP) shift_reg[0] <= tdi;
                else shift_reg <= {tdi, shift_reg[DR_W-1:1]};
                if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end else if (vs_udr && in_scan) begin
                state <= S_UPD;
                if (mode == M_DATA) begin
                    if (cnt == CNT_FULL) begin
                        upd_data  <= shift_reg;
                        upd_ch    <= chan;
                        upd_valid <= 1'b1;
`ifdef VJTAG_DR_AUTOINC_EN
                        chan <= (chan == CH_LAST) ? 8'd0 : chan + 8'd1;
`endif
                    end else if (cnt < CNT_FULL) begin
                        err_short <= 1'b1;
                    end else begin
                        err_long <= 1'b1;
                    end
                end
            end else if (state == S_UPD) begin
                state <= S_IDLE;
            end
            // IR writes land last so they override a same-cycle auto-increment
            if (vs_uir) begin
                case (ir_in[7:0])
                    8'h01: begin
                        if (int'(ir_in[15:8]) < N_CH) begin
                            mode <= M_DATA;
                            chan <= ir_in[15:8];
                        end else begin
                            mode <= M_BYP;
                        end
                    end
                    8'h02: mode <= M_ID;
                    8'h03: begin
                        err_short <= 1'b0;
                        err_long  <= 1'b0;
                        mode      <= M_BYP;
                    end
                    default: mode <= M_BYP;
                endcase
            end
        end
    end

`ifndef VJTAG_DR_AUTOINC_EN
    logic unused_last;
    assign unused_last = ^CH_LAST;
`endif

endmodule

// File: tb/tb_vjtag_dr_engine.sv
// Randomised self-checking bench for vjtag_dr_engine with a bit-stream reference model.
// Follows VJTAG_DR_AUTOINC_EN when the macro is defined for the build.
module tb_vjtag_dr_engine;

    logic         clk = 1'b0;
    logic         rst;
    logic         tdi;
    logic         tdo;
    logic [23:0]  ir_in;
    logic [23:0]  ir_out;
    logic         vs_cdr, vs_sdr, vs_udr, vs_uir;
    logic [127:0] cap_data;
    logic [31:0]  upd_data;
    logic [7:0]   upd_ch;
    logic         upd_valid;

    int total = 0;
    int bad   = 0;

    vjtag_dr_engine dut (
        .clk(clk), .rst(rst), .tdi(tdi), .tdo(tdo),
        .ir_in(ir_in), .ir_out(ir_out),
        .vs_cdr(vs_cdr), .vs_sdr(vs_sdr), .vs_udr(vs_udr), .vs_uir(vs_uir),
        .cap_data(cap_data), .upd_data(upd_data), .upd_ch(upd_ch),
        .upd_valid(upd_valid)
    );

    always #5 clk = ~clk;

    // reference model state: mode 0=BYPASS 1=DATA 2=ID
    int         m_mode;
    logic [7:0] m_chan;
    logic       m_es, m_el;
    logic [31:0] m_data;
    logic [7:0]  m_ch;

    // observed and expected results of the last DR scan
    logic [63:0] o_tdo, e_tdo;
    logic        o_after, e_after;
    logic        o_v1, e_valid, o_v2;
    logic [31:0] o_data;
    logic [7:0]  o_ch;
    logic [23:0] o_ir;

    function automatic logic [23:0] exp_ir();
        return {8'h00, m_chan, 5'b0, (m_mode == 1), m_el, m_es};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_chan = 0; m_es = 0; m_el = 0;
        m_data = 0; m_ch = 0;
    endtask

    task automatic model_ir(input logic [7:0] op, input logic [7:0] arg);
        if (op == 8'h01) begin
            if (arg < 4) begin m_mode = 1; m_chan = arg; end
            else m_mode = 0;
        end else if (op == 8'h02) begin
            m_mode = 2;
        end else if (op == 8'h03) begin
            m_es = 0; m_el = 0; m_mode = 0;
        end else begin
            m_mode = 0;
        end
    endtask

    // the DR is a window sliding over the captured bits followed by tdi bits
    task automatic model_scan(input int n, input logic [63:0] d);
        bit q[$];
        logic [31:0] cw;
        cw = (m_mode == 1) ? cap_data[m_chan*32 +: 32] : 32'h4A50_0001;
        if (m_mode == 0) q.push_back(1'b0);
        else for (int i = 0; i < 32; i++) q.push_back(cw[i]);
        for (int i = 0; i < n; i++) q.push_back(d[i]);
        e_tdo = '0;
        for (int i = 0; i < n; i++) e_tdo[i] = q[i];
        e_after = q[n];
        e_valid = (m_mode == 1) && (n == 32);
        if (e_valid) begin
            for (int i = 0; i < 32; i++) m_data[i] = q[n+i];
            m_ch = m_chan;
`ifdef VJTAG_DR_AUTOINC_EN
            m_chan = (m_chan == 3) ? 8'd0 : m_chan + 8'd1;
`endif
        end else if (m_mode == 1) begin
            if (n < 32) m_es = 1;
            else m_el = 1;
        end
    endtask

    task automatic ir_scan(input logic [7:0] op, input logic [7:0] arg);
        @(negedge clk);
        ir_in = {8'(op ^ arg), arg, op};
        vs_uir = 1;
        @(negedge clk);
        vs_uir = 0;
        @(negedge clk);
        model_ir(op, arg);
    endtask

    task automatic dr_scan(input int n, input logic [63:0] d);
        model_scan(n, d);
        o_tdo = '0;
        @(negedge clk);
        vs_cdr = 1;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vs_cdr = 0;
            o_tdo[i] = tdo;
            tdi = d[i];
            vs_sdr = 1;
        end
        @(negedge clk);
        vs_cdr = 0;
        vs_sdr = 0;
        o_after = tdo;
        vs_udr = 1;
        @(negedge clk);
        vs_udr = 0;
        o_v1 = upd_valid;
        o_data = upd_data;
        o_ch = upd_ch;
        @(negedge clk);
        o_v2 = upd_valid;
        o_ir = ir_out;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total += 5;
        if (tdo !== 1'b0) begin bad++; $display("FAIL reset_tdo got=%b exp=0", tdo); end
        if (upd_data !== 32'h0) begin bad++; $display("FAIL reset_upd_data got=%h exp=0", upd_data); end
        if (upd_ch !== 8'h0) begin bad++; $display("FAIL reset_upd_ch got=%h exp=0", upd_ch); end
        if (upd_valid !== 1'b0) begin bad++; $display("FAIL reset_upd_valid got=%b exp=0", upd_valid); end
        if (ir_out !== 24'h0) begin bad++; $display("FAIL reset_ir_out got=%h exp=0", ir_out); end
    endtask

    task automatic test_bypass();
        logic [63:0] d;
        dr_scan(1, 64'h1);
        total += 3;
        if (o_after !== 1'b1) begin bad++; $display("FAIL byp_tdo got=%b exp=1", o_after); end
        if (o_v1 !== 1'b0) begin bad++; $display("FAIL byp_valid got=%b exp=0", o_v1); end
        if (o_ir !== exp_ir()) begin bad++; $display("FAIL byp_ir got=%h exp=%h", o_ir, exp_ir()); end
        d = {$urandom, $urandom};
        dr_scan(20, d);
        total += 1;
        if (o_tdo !== e_tdo) begin bad++; $display("FAIL byp_stream got=%h exp=%h", o_tdo, e_tdo); end
    endtask

    task automatic test_data();
        cap_data[2*32 +: 32] = 32'hDEAD_BEEF;
        ir_scan(8'h01, 8'h02);
        total += 1;
        if (ir_out !== exp_ir()) begin bad++; $display("FAIL data_ir got=%h exp=%h", ir_out, exp_ir()); end
        dr_scan(32, 64'h1234_5678);
        total += 5;
        if (o_tdo[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL data_tdo got=%h exp=deadbeef", o_tdo[31:0]); end
        if (o_v1 !== 1'b1) begin bad++; $display("FAIL data_valid got=%b exp=1", o_v1); end
        if (o_data !== 32'h1234_5678) begin bad++; $display("FAIL data_word got=%h exp=12345678", o_data); end
        if (o_ch !== 8'd2) begin bad++; $display("FAIL data_ch got=%0d exp=2", o_ch); end
        if (o_v2 !== 1'b0) begin bad++; $display("FAIL data_pulse got=%b exp=0", o_v2); end
    endtask

    task automatic test_len_errors();
        ir_scan(8'h01, 8'h00);
        dr_scan(31, {$urandom, $urandom});
        total += 2;
        if (o_v1 !== 1'b0) begin bad++; $display("FAIL short_valid got=%b exp=0", o_v1); end
        if (o_ir[1:0] !== 2'b01) begin bad++; $display("FAIL short_flag got=%b exp=01", o_ir[1:0]); end
        if (m_chan != 0) ir_scan(8'h01, 8'h00);
        dr_scan(33, {$urandom, $urandom});
        total += 2;
        if (o_v1 !== 1'b0) begin bad++; $display("FAIL long_valid got=%b exp=0", o_v1); end
        if (o_ir[1:0] !== 2'b11) begin bad++; $display("FAIL long_flag got=%b exp=11", o_ir[1:0]); end
        ir_scan(8'h03, 8'h00);
        total += 1;
        if (ir_out !== exp_ir() || ir_out[1:0] !== 2'b00) begin
            bad++; $display("FAIL clr_flags got=%h exp=%h", ir_out, exp_ir());
        end
    endtask

    task automatic test_id();
        ir_scan(8'h02, 8'h00);
        dr_scan(32, {$urandom, $urandom});
        total += 3;
        if (o_tdo[31:0] !== 32'h4A50_0001) begin bad++; $display("FAIL id_tdo got=%h exp=4a500001", o_tdo[31:0]); end
        if (o_v1 !== 1'b0) begin bad++; $display("FAIL id_valid got=%b exp=0", o_v1); end
        if (o_ir !== exp_ir()) begin bad++; $display("FAIL id_ir got=%h exp=%h", o_ir, exp_ir()); end
    endtask

    task automatic test_bad_arg();
        ir_scan(8'h01, 8'h07);
        dr_scan(32, {$urandom, $urandom});
        total += 3;
        if (o_v1 !== 1'b0) begin bad++; $display("FAIL badarg_valid got=%b exp=0", o_v1); end
        if (o_ir[2:0] !== 3'b000) begin bad++; $display("FAIL badarg_status got=%b exp=000", o_ir[2:0]); end
        if (o_ir !== exp_ir()) begin bad++; $display("FAIL badarg_ir got=%h exp=%h", o_ir, exp_ir()); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] want[3];
`ifdef VJTAG_DR_AUTOINC_EN
        want = '{8'd3, 8'd0, 8'd1};
`else
        want = '{8'd3, 8'd3, 8'd3};
`endif
        ir_scan(8'h01, 8'h03);
        for (int i = 0; i < 3; i++) begin
            dr_scan(32, {32'h0, $urandom});
            total += 4;
            if (o_v1 !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d] got=%b exp=1", i, o_v1); end
            if (o_ch !== want[i]) begin bad++; $display("FAIL b2b_ch[%0d] got=%0d exp=%0d", i, o_ch, want[i]); end
            if (o_data !== m_data) begin bad++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, o_data, m_data); end
            if (o_v2 !== 1'b0) begin bad++; $display("FAIL b2b_pulse[%0d] got=%b exp=0", i, o_v2); end
        end
    endtask

    task automatic test_reset_midscan();
        ir_scan(8'h01, 8'h01);
        @(negedge clk); vs_cdr = 1;
        @(negedge clk); vs_cdr = 0; vs_sdr = 1; tdi = 1;
        @(negedge clk); vs_sdr = 0; rst = 1;
        @(negedge clk); rst = 0;
        model_reset();
        @(negedge clk);
        total += 3;
        if (ir_out !== 24'h0) begin bad++; $display("FAIL midrst_ir got=%h exp=0", ir_out); end
        if (upd_data !== 32'h0) begin bad++; $display("FAIL midrst_data got=%h exp=0", upd_data); end
        if (tdo !== 1'b0) begin bad++; $display("FAIL midrst_tdo got=%b exp=0", tdo); end
        ir_scan(8'h01, 8'h01);
        for (int i = 0; i < 32; i++) begin
            @(negedge clk); vs_sdr = 1; tdi = 1'($urandom);
        end
        @(negedge clk); vs_sdr = 0; vs_udr = 1;
        @(negedge clk); vs_udr = 0;
        total += 1;
        if (upd_valid !== 1'b0) begin bad++; $display("FAIL nocdr_valid got=%b exp=0", upd_valid); end
        @(negedge clk);
        total += 1;
        if (ir_out !== exp_ir()) begin bad++; $display("FAIL nocdr_ir got=%h exp=%h", ir_out, exp_ir()); end
    endtask

    task automatic test_random();
        logic [7:0] op, arg;
        int n, pick;
        for (int it = 0; it < 24; it++) begin
            cap_data = {$urandom, $urandom, $urandom, $urandom};
            pick = $urandom_range(0, 5);
            op = (pick < 3) ? 8'h01 : (pick == 3) ? 8'h02 : (pick == 4) ? 8'h03 : 8'($urandom_range(4, 255));
            arg = 8'($urandom_range(0, 5));
            ir_scan(op, arg);
            pick = $urandom_range(0, 4);
            n = (pick < 2) ? 32 : (pick == 2) ? 31 : (pick == 3) ? 33 : $urandom_range(1, 40);
            dr_scan(n, {$urandom, $urandom});
            total += 6;
            if (o_tdo !== e_tdo) begin bad++; $display("FAIL rnd_tdo[%0d] got=%h exp=%h", it, o_tdo, e_tdo); end
            if (o_after !== e_after) begin bad++; $display("FAIL rnd_after[%0d] got=%b exp=%b", it, o_after, e_after); end
            if (o_v1 !== e_valid) begin bad++; $display("FAIL rnd_valid[%0d] got=%b exp=%b", it, o_v1, e_valid); end
            if (o_data !== m_data || o_ch !== m_ch) begin
                bad++; $display("FAIL rnd_upd[%0d] got=%h/%0d exp=%h/%0d", it, o_data, o_ch, m_data, m_ch);
            end
            if (o_v2 !== 1'b0) begin bad++; $display("FAIL rnd_pulse[%0d] got=%b exp=0", it, o_v2); end
            if (o_ir !== exp_ir()) begin bad++; $display("FAIL rnd_ir[%0d] got=%h exp=%h", it, o_ir, exp_ir()); end
        end
    endtask

    initial begin
        rst = 1; tdi = 0; ir_in = '0;
        vs_cdr = 0; vs_sdr = 0; vs_udr = 0; vs_uir = 0;
        cap_data = {$urandom, $urandom, $urandom, $urandom};
        model_reset();
        test_reset();
        test_bypass();
        test_data();
        test_len_errors();
        test_id();
        test_bad_arg();
        test_back_to_back();
        test_reset_midscan();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
